fetch_ctrl: RTL and testbench
=============================

FETCH_CTRL -- requirements
Module: fetch_ctrl

Interface
REQ-001 The block SHALL have parameter RESET_PC, default 32'h00003000, the first fetch address after reset.
REQ-002 The block SHALL have port clk, input, 1, the single clock; all state changes on its rising edge.
REQ-003 The block SHALL have port rst, input, 1, the asynchronous active-low reset (asserted at 0).
REQ-004 The block SHALL have port imem_req, output, 1, the instruction-memory request valid.
REQ-005 The block SHALL have port imem_addr, output, 32, the request address.
REQ-006 The block SHALL have port imem_gnt, input, 1, the memory's acceptance of the request this cycle.
REQ-007 The block SHALL have port imem_rvalid, input, 1, the response valid (at least 1 cycle after grant).
REQ-008 The block SHALL have port imem_rdata, input, 32, the response instruction word.
REQ-009 The block SHALL have port redir_valid, input, 1, the branch/jump redirect strobe.
REQ-010 The block SHALL have port redir_pc, input, 32, the redirect target.
REQ-011 The block SHALL have port out_valid, output, 1, meaning an instruction is held for IF/ID.
REQ-012 The block SHALL have port out_pc, output, 32, the address of the held instruction.
REQ-013 The block SHALL have port out_instr, output, 32, the held instruction.
REQ-014 The block SHALL have port out_ready, input, 1, the downstream accept (low = pipeline stall).
REQ-015 The block SHALL have port pc, output, 32, the next address to be requested.

Function
REQ-016 The FSM SHALL have the states IDLE, REQ, WAIT and FULL, with at most one request outstanding at any time.
REQ-017 IDLE SHALL go to REQ on the first clock edge after reset release.
REQ-018 In REQ: imem_req=1 and imem_addr=pc; on imem_gnt, fetch_pc<=pc, pc<=pc+4 and the FSM goes to WAIT; with no grant, req/addr SHALL be held stable.
REQ-019 In WAIT, on imem_rvalid the block SHALL capture {fetch_pc, imem_rdata} into the output buffer and go to FULL; if the kill flag is set, it SHALL instead discard the response, clear kill and go to REQ.
REQ-020 In FULL, out_valid SHALL be 1 and out_pc/out_instr SHALL be held stable; on out_ready the FSM SHALL go to REQ and out_valid SHALL drop on the next cycle.
REQ-021 Any out_ready held low SHALL keep the FSM in FULL indefinitely with no new request.
REQ-022 A redirect SHALL take priority over pc+4: on redir_valid, pc SHALL load {redir_pc[31:2],2'b00} at the next edge.
REQ-023 A redirect in FULL SHALL flush the buffer (out_valid=0 next cycle) and go to REQ, including when out_ready is high in the same cycle.
REQ-024 A redirect in WAIT SHALL set kill and stay in WAIT.
REQ-025 A redirect in REQ without imem_gnt SHALL stay in REQ with the new pc.
REQ-026 A redirect in REQ with imem_gnt in the same cycle SHALL go to WAIT with kill=1 and pc=the redirect target.
REQ-027 A redirect coinciding with imem_rvalid in WAIT SHALL discard that response and go to REQ.
REQ-028 pc arithmetic SHALL be modulo 2^32: 32'hFFFFFFFC+4 gives 32'h00000000.
REQ-029 imem_rvalid outside WAIT SHALL be ignored.

Reset
REQ-030 While rst=0, the block SHALL hold: state=IDLE, pc=RESET_PC, fetch_pc=RESET_PC, kill=0, imem_req=0, out_valid=0, out_pc=0, out_instr=0.
REQ-031 Reset SHALL take effect asynchronously; a reset asserted mid-request abandons the request, and any later stale imem_rvalid SHALL be ignored.

Structure
REQ-032 The shared package fetch_pkg SHALL hold the RESET_PC default, the state encoding (2-bit) and the NOP word 32'h00000000.
REQ-033 The output buffer (valid, pc, instr, with load/flush/pop) SHALL be a sub-module named fetch_buf.

Verification
REQ-034 The bench SHALL cover: reset release, gnt immediate, rvalid 1 cycle later, out_ready=1 -> out_pc sequence 0x3000, 0x3004, 0x3008; first imem_req 1 cycle after release.
REQ-035 The bench SHALL cover: out_ready=0 for 10 cycles while FULL -> out_valid stays 1, out_instr constant, imem_req=0 throughout.
REQ-036 The bench SHALL cover: redir_valid with redir_pc=0x3100 during WAIT for 0x3008 -> 0x3008 response dropped, next imem_addr=0x3100, next out_pc=0x3100.
REQ-037 The bench SHALL cover: redir_valid with gnt in the same REQ cycle (target 0x4002) -> granted fetch killed, pc=0x4000, next out_pc=0x4000.
REQ-038 The bench SHALL cover: pc forced to 0xFFFFFFFC via redirect -> following request address 0x00000000.
REQ-039 The bench SHALL cover: rst pulsed low during WAIT, then a stale rvalid -> out_valid stays 0, first request address 0x3000.

Source files
------------

// File: rtl/fetch_pkg.sv
// rtl/fetch_pkg.sv - shared constants, state encoding and helpers for the fetch controller
package fetch_pkg;

  localparam logic [31:0] RESET_PC_DEFAULT = 32'h00003000;
  localparam logic [31:0] NOP_INSTR        = 32'h00000000;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_WAIT = 2'd2,
    ST_FULL = 2'd3
  } fetch_state_t;

  // Instructions are word aligned; redirect targets drop their low two bits.
  function automatic logic [31:0] align_pc(input logic [31:0] addr);
    return {addr[31:2], 2'b00};
  endfunction

endpackage

// File: rtl/fetch_buf.sv
// rtl/fetch_buf.sv - single-entry output buffer holding the fetched instruction for IF/ID
module fetch_buf
  import fetch_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        load,
  input  logic [31:0] load_pc,
  input  logic [31:0] load_instr,
  input  logic        flush,
  input  logic        pop,
  output logic        valid,
  output logic [31:0] buf_pc,
  output logic [31:0] buf_instr
);

  // Flush and pop both empty the entry; the pc/instr fields only change on load
  // so they stay stable for as long as the entry is held.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      valid     <= 1'b0;
      buf_pc    <= 32'h0;
      buf_instr <= NOP_INSTR;
    end else if (flush || pop) begin
      valid <= 1'b0;
    end else if (load) begin
      valid     <= 1'b1;
      buf_pc    <= load_pc;
      buf_instr <= load_instr;
    end
  end

endmodule

// File: rtl/fetch_ctrl.sv
// rtl/fetch_ctrl.sv - instruction fetch controller with one outstanding request and redirect/kill handling
module fetch_ctrl
  import fetch_pkg::*;
#(
  parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT
) (
  input  logic        clk,
  input  logic        rst,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_gnt,
  input  logic        imem_rvalid,
  input  logic [31:0] imem_rdata,
  input  logic        redir_valid,
  input  logic [31:0] redir_pc,
  output logic        out_valid,
  output logic [31:0] out_pc,
  output logic [31:0] out_instr,
  input  logic        out_ready,
  output logic [31:0] pc
);

  fetch_state_t state_q, state_d;
  logic [31:0]  pc_q;
  logic [31:0]  fetch_pc_q;
  logic         kill_q;
  logic         buf_load;
  logic         buf_flush;
  logic         buf_pop;
  logic         granted;

  assign granted = (state_q == ST_REQ) && imem_gnt;

  // State register; IDLE is only left on the first edge after reset release.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state_q <= ST_IDLE;
    else      state_q <= state_d;
  end

  // Next-state: a response that was killed (earlier or by a coincident redirect) returns to REQ.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: state_d = ST_REQ;
      ST_REQ:  if (imem_gnt) state_d = ST_WAIT;
      ST_WAIT: if (imem_rvalid) state_d = (kill_q || redir_valid) ? ST_REQ : ST_FULL;
      ST_FULL: if (redir_valid || out_ready) state_d = ST_REQ;
      default: state_d = ST_IDLE;
    endcase
  end

  // Output/control decode: request in REQ, buffer load/flush/pop strobes.
  always_comb begin
    imem_req  = 1'b0;
    buf_load  = 1'b0;
    buf_flush = 1'b0;
    buf_pop   = 1'b0;
    case (state_q)
      ST_REQ:  imem_req = 1'b1;
      ST_WAIT: buf_load = imem_rvalid && !kill_q && !redir_valid;
      ST_FULL: begin
        buf_flush = redir_valid;
        buf_pop   = out_ready && !redir_valid;
      end
      default: ;
    endcase
  end

  // PC, in-flight address and kill flag; a redirect always wins over the sequential increment.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pc_q       <= RESET_PC;
      fetch_pc_q <= RESET_PC;
      kill_q     <= 1'b0;
    end else begin
      if (redir_valid)  pc_q <= align_pc(redir_pc);
      else if (granted) pc_q <= pc_q + 32'd4;

      if (granted) fetch_pc_q <= pc_q;

      if (state_q == ST_WAIT && imem_rvalid)      kill_q <= 1'b0;
      else if (state_q == ST_WAIT && redir_valid) kill_q <= 1'b1;
      else if (granted && redir_valid)            kill_q <= 1'b1;
    end
  end

  assign imem_addr = pc_q;
  assign pc        = pc_q;

  fetch_buf u_buf (
    .clk        (clk),
    .rst        (rst),
    .load       (buf_load),
    .load_pc    (fetch_pc_q),
    .load_instr (imem_rdata),
    .flush      (buf_flush),
    .pop        (buf_pop),
    .valid      (out_valid),
    .buf_pc     (out_pc),
    .buf_instr  (out_instr)
  );

endmodule

// File: tb/tb_fetch_ctrl.sv
// tb/tb_fetch_ctrl.sv - scoreboard bench for fetch_ctrl
module tb_fetch_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_gnt;
  logic        imem_rvalid;
  logic [31:0] imem_rdata;
  logic        redir_valid;
  logic [31:0] redir_pc;
  logic        out_valid;
  logic [31:0] out_pc;
  logic [31:0] out_instr;
  logic        out_ready;
  logic [31:0] pc;

  int vectors = 0;
  int miscompares = 0;
  logic [63:0] exp_q[$];

  localparam logic [31:0] STALE_WORD = 32'hDEADBEEF;

  fetch_ctrl #(.RESET_PC(32'h00003000)) dut (
    .clk         (clk),
    .rst         (rst),
    .imem_req    (imem_req),
    .imem_addr   (imem_addr),
    .imem_gnt    (imem_gnt),
    .imem_rvalid (imem_rvalid),
    .imem_rdata  (imem_rdata),
    .redir_valid (redir_valid),
    .redir_pc    (redir_pc),
    .out_valid   (out_valid),
    .out_pc      (out_pc),
    .out_instr   (out_instr),
    .out_ready   (out_ready),
    .pc          (pc)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] instr_of(input logic [31:0] a);
    return {a[15:0], ~a[15:0]} ^ 32'h13579BDF;
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    if (obs !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic wait_req(input logic [31:0] exp_addr);
    int n = 0;
    while (!imem_req && n < 20) begin
      tick();
      n++;
    end
    check("req_seen", {31'b0, imem_req}, 32'd1);
    check("req_addr", imem_addr, exp_addr);
  endtask

  task automatic wait_out();
    int n = 0;
    logic [63:0] e;
    while (!out_valid && n < 20) begin
      tick();
      n++;
    end
    check("out_valid_seen", {31'b0, out_valid}, 32'd1);
    if (exp_q.size() == 0) begin
      check("sb_underflow", 32'd0, 32'd1);
    end else begin
      e = exp_q.pop_front();
      check("out_pc", out_pc, e[63:32]);
      check("out_instr", out_instr, e[31:0]);
    end
  endtask

  // Immediate grant, response one cycle later; optionally leave the instruction held.
  task automatic do_fetch(input logic [31:0] exp_addr, input bit hold);
    wait_req(exp_addr);
    imem_gnt = 1'b1;
    tick();
    imem_gnt    = 1'b0;
    imem_rvalid = 1'b1;
    imem_rdata  = instr_of(exp_addr);
    exp_q.push_back({exp_addr, instr_of(exp_addr)});
    tick();
    imem_rvalid = 1'b0;
    imem_rdata  = 32'h0;
    wait_out();
    if (!hold) begin
      out_ready = 1'b1;
      tick();
      out_ready = 1'b0;
      check("pop_drop", {31'b0, out_valid}, 32'd0);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b0; imem_gnt = 1'b0; imem_rvalid = 1'b0; imem_rdata = 32'h0;
    redir_valid = 1'b0; redir_pc = 32'h0; out_ready = 1'b0;
    repeat (3) tick();
    check("rst_req", {31'b0, imem_req}, 32'd0);
    check("rst_valid", {31'b0, out_valid}, 32'd0);
    check("rst_out_pc", out_pc, 32'h0);
    check("rst_out_instr", out_instr, 32'h0);
    check("rst_pc", pc, 32'h00003000);

    // Release: IDLE for one cycle, request on the next.
    rst = 1'b1;
    check("idle_req", {31'b0, imem_req}, 32'd0);
    tick();
    check("first_req", {31'b0, imem_req}, 32'd1);
    check("first_addr", imem_addr, 32'h00003000);
    do_fetch(32'h00003000, 1'b0);
    do_fetch(32'h00003004, 1'b0);
    do_fetch(32'h00003008, 1'b0);

    // Stall ten cycles with the instruction held.
    do_fetch(32'h0000300C, 1'b1);
    for (int i = 0; i < 10; i++) begin
      check("stall_valid", {31'b0, out_valid}, 32'd1);
      check("stall_instr", out_instr, instr_of(32'h0000300C));
      check("stall_req", {31'b0, imem_req}, 32'd0);
      tick();
    end

    // Redirect in FULL with out_ready high flushes the buffer.
    redir_valid = 1'b1; redir_pc = 32'h00005000; out_ready = 1'b1;
    tick();
    redir_valid = 1'b0; out_ready = 1'b0;
    check("full_redir_flush", {31'b0, out_valid}, 32'd0);
    do_fetch(32'h00005000, 1'b0);

    // Reset during WAIT, then stale responses in IDLE and REQ.
    wait_req(32'h00005004);
    imem_gnt = 1'b1;
    tick();
    imem_gnt = 1'b0;
    rst = 1'b0;
    #1;
    check("async_rst_req", {31'b0, imem_req}, 32'd0);
    check("async_rst_pc", pc, 32'h00003000);
    tick();
    rst = 1'b1;
    imem_rvalid = 1'b1; imem_rdata = STALE_WORD;
    tick();
    check("stale_req", {31'b0, imem_req}, 32'd1);
    check("stale_addr", imem_addr, 32'h00003000);
    tick();
    imem_rvalid = 1'b0;
    check("stale_valid", {31'b0, out_valid}, 32'd0);
    do_fetch(32'h00003000, 1'b0);
    do_fetch(32'h00003004, 1'b0);

    // Redirect while waiting on 0x3008: response dropped.
    wait_req(32'h00003008);
    imem_gnt = 1'b1;
    tick();
    imem_gnt = 1'b0; redir_valid = 1'b1; redir_pc = 32'h00003100;
    tick();
    redir_valid = 1'b0; imem_rvalid = 1'b1; imem_rdata = STALE_WORD;
    tick();
    imem_rvalid = 1'b0;
    check("wait_kill_valid", {31'b0, out_valid}, 32'd0);
    do_fetch(32'h00003100, 1'b0);

    // Redirect coincident with grant: granted fetch killed.
    wait_req(32'h00003104);
    imem_gnt = 1'b1; redir_valid = 1'b1; redir_pc = 32'h00004002;
    tick();
    imem_gnt = 1'b0; redir_valid = 1'b0;
    check("gnt_redir_pc", pc, 32'h00004000);
    imem_rvalid = 1'b1; imem_rdata = STALE_WORD;
    tick();
    imem_rvalid = 1'b0;
    check("gnt_kill_valid", {31'b0, out_valid}, 32'd0);
    do_fetch(32'h00004000, 1'b0);

    // Redirect in REQ without grant to the top of the address space, then wrap.
    wait_req(32'h00004004);
    redir_valid = 1'b1; redir_pc = 32'hFFFFFFFE;
    tick();
    redir_valid = 1'b0;
    do_fetch(32'hFFFFFFFC, 1'b0);
    do_fetch(32'h00000000, 1'b0);

    check("sb_empty", exp_q.size(), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
